pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage WISC-SP20 core.
- Merges the decode hazard stall, execute branch redirect, multi-cycle instruction/data memory misses and halt into per-stage enable/flush/bubble controls.
- Sits beside the hazard detector and drives the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipe registers.
- Keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: folds hazard, redirect, I/D-miss and halt into per-stage enable/flush/bubble controls.
// Controls are combinational from state and inputs (zero latency); halted, counters and flush_pend are registered.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             branch_flush,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    input  logic             halt_wb,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF   = '0;
    localparam ctrl_t CTRL_RST   = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
                                     id_ex_bubble: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
                                     mem_wb_bubble: 1'b1};
    localparam ctrl_t CTRL_DMISS = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
                                     id_ex_bubble: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
                                     mem_wb_bubble: 1'b1};

    state_e           state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    ctrl_t            ctrl;
    logic             run_rules;
    logic             dmem_mask;
    logic             flush_take;
    logic             stall_inc;

    // Back end drains; decode either advances or holds with a bubble into ID_EX.
    function automatic ctrl_t drain(input logic hold);
        ctrl_t c;
        c               = CTRL_OFF;
        c.id_ex_en      = 1'b1;
        c.ex_mem_en     = 1'b1;
        c.mem_wb_en     = 1'b1;
        c.pc_en         = ~hold;
        c.if_id_en      = ~hold;
        c.id_ex_bubble  = hold;
        return c;
    endfunction

    always_comb begin
        ctrl         = CTRL_OFF;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        flush_take   = 1'b0;
        run_rules    = 1'b0;
        dmem_mask    = 1'b0;

        case (state_q)
            ST_RUN: begin
                run_rules = 1'b1;
            end
            ST_DWAIT: begin
                if (dmem_done) begin
                    run_rules = 1'b1;
                    dmem_mask = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    ctrl = CTRL_DMISS;
                end
            end
            ST_IWAIT: begin
                ctrl             = drain(hazard_stall);
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_en    = 1'b0;
                ctrl.if_id_flush = ~hazard_stall;
                if (branch_flush) begin
                    ctrl.pc_en        = 1'b1;
                    ctrl.if_id_flush  = 1'b1;
                    ctrl.id_ex_bubble = 1'b1;
                    flush_take        = 1'b1;
                    if (imem_done) begin
                        flush_pend_d = 1'b0;
                        state_d      = ST_RUN;
                    end else begin
                        flush_pend_d = 1'b1;
                    end
                end else if (imem_done) begin
                    flush_pend_d = 1'b0;
                    state_d      = ST_RUN;
                    // A redirect seen mid-miss means the returning word is on the wrong path.
                    if (flush_pend_q) begin
                        ctrl.if_id_flush = 1'b1;
                    end else begin
                        ctrl.if_id_flush = 1'b0;
                        ctrl.pc_en       = ~hazard_stall;
                        ctrl.if_id_en    = ~hazard_stall;
                    end
                end
            end
            default: begin
                ctrl = CTRL_OFF;
            end
        endcase

        if (run_rules) begin
            if (halt_wb) begin
                ctrl    = CTRL_OFF;
                state_d = ST_HALT;
            end else if (dmem_stall && !dmem_mask) begin
                ctrl    = CTRL_DMISS;
                state_d = ST_DWAIT;
            end else if (branch_flush) begin
                ctrl             = drain(1'b1);
                ctrl.pc_en       = 1'b1;
                ctrl.if_id_flush = 1'b1;
                flush_take       = 1'b1;
                state_d          = ST_RUN;
            end else if (imem_stall) begin
                ctrl             = drain(hazard_stall);
                ctrl.pc_en       = 1'b0;
                ctrl.if_id_en    = 1'b0;
                ctrl.if_id_flush = ~hazard_stall;
                state_d          = ST_IWAIT;
            end else begin
                ctrl    = drain(hazard_stall);
                state_d = ST_RUN;
            end
        end

        if (rst) begin
            ctrl = CTRL_RST;
        end
    end

    assign stall_inc = ~ctrl.pc_en && (state_q != ST_HALT);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_take && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_pend_q <= 1'b0;
            halted_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            halted_q     <= (state_d == ST_HALT);
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_en      = ctrl.id_ex_en;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign halted        = halted_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand sequences, then random stimulus against a reference model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_stall, branch_flush, imem_stall, imem_done;
    logic        dmem_stall, dmem_done, halt_wb;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic        ex_mem_en, mem_wb_en, mem_wb_bubble, halted;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble;
    logic        s_ex_mem_en, s_mem_wb_en, s_mem_wb_bubble, s_halted;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_flush(branch_flush),
        .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall),
        .dmem_done(dmem_done), .halt_wb(halt_wb), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .branch_flush(branch_flush),
        .imem_stall(imem_stall), .imem_done(imem_done), .dmem_stall(dmem_stall),
        .dmem_done(dmem_done), .halt_wb(halt_wb), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
        .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en), .id_ex_bubble(s_id_ex_bubble),
        .ex_mem_en(s_ex_mem_en), .mem_wb_en(s_mem_wb_en), .mem_wb_bubble(s_mem_wb_bubble),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Input order: hazard, branch, imem_stall, imem_done, dmem_stall, dmem_done, halt_wb
    localparam logic [6:0] I_HZ = 7'b1000000;
    localparam logic [6:0] I_BR = 7'b0100000;
    localparam logic [6:0] I_IS = 7'b0010000;
    localparam logic [6:0] I_ID = 7'b0001000;
    localparam logic [6:0] I_DS = 7'b0000100;
    localparam logic [6:0] I_DD = 7'b0000010;
    localparam logic [6:0] I_HT = 7'b0000001;

    // Output order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en, mem_wb_bubble, halted
    localparam logic [8:0] RST_C = 9'b0_0_1_0_1_0_0_1_0;
    localparam logic [8:0] RUN_C = 9'b1_1_0_1_0_1_1_0_0;
    localparam logic [8:0] HAZ_C = 9'b0_0_0_1_1_1_1_0_0;
    localparam logic [8:0] DMS_C = 9'b0_0_0_0_0_0_1_1_0;
    localparam logic [8:0] IMS_C = 9'b0_0_1_1_0_1_1_0_0;
    localparam logic [8:0] BRF_C = 9'b1_0_1_1_1_1_1_0_0;
    localparam logic [8:0] HLT0  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] HLT1  = 9'b0_0_0_0_0_0_0_0_1;

    typedef struct {
        logic       r;
        logic [6:0] in;
        logic [8:0] ctrl;
        int         st;
        int         fl;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    bit   m_halt, m_fwait, m_dwait, m_owed;
    int   m_stall, m_flush;

    function automatic void add(input logic r, input logic [6:0] in, input logic [8:0] c,
                                input int st, input int fl);
        vec_t v;
        v.r = r; v.in = in; v.ctrl = c; v.st = st; v.fl = fl;
        tbl.push_back(v);
    endfunction

    function automatic int sat(input int x, input int lim);
        return (x > lim) ? lim : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step(input string name, input logic r, input logic [6:0] v,
                        input logic [8:0] c, input int st, input int fl);
        @(negedge clk);
        rst = r;
        {hazard_stall, branch_flush, imem_stall, imem_done, dmem_stall, dmem_done, halt_wb} = v;
        #1;
        chk({name, " ctrl"}, {23'd0, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                              ex_mem_en, mem_wb_en, mem_wb_bubble, halted}, {23'd0, c});
        chk({name, " ctrl4"}, {23'd0, s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble,
                               s_ex_mem_en, s_mem_wb_en, s_mem_wb_bubble, s_halted}, {23'd0, c});
        chk({name, " stall_cnt"}, {16'd0, stall_cnt}, 32'(sat(st, 65535)));
        chk({name, " flush_cnt"}, {16'd0, flush_cnt}, 32'(sat(fl, 65535)));
        chk({name, " stall_cnt4"}, {28'd0, s_stall_cnt}, 32'(sat(st, 15)));
        chk({name, " flush_cnt4"}, {28'd0, s_flush_cnt}, 32'(sat(fl, 15)));
    endtask

    // Reference: decides who owns the pipeline this cycle, returns expected controls and
    // pre-edge counters, then advances its own bookkeeping.
    task automatic model_step(input logic r, input logic [6:0] v, output logic [8:0] e,
                              output int e_st, output int e_fl);
        bit hz, br, is, id, ds, dd, ht;
        bit pc, ifen, iffl, idexen, bub, exm, mwen, mwbub;
        bit go_halt, go_f, go_d, owed, took;
        {hz, br, is, id, ds, dd, ht} = v;
        {pc, ifen, iffl, idexen, bub, exm, mwen, mwbub} = 8'd0;
        e_st = m_stall;
        e_fl = m_flush;
        go_halt = m_halt; go_f = m_fwait; go_d = m_dwait; owed = m_owed; took = 1'b0;
        if (r) begin
            e = RST_C | {8'd0, m_halt};
            m_halt = 0; m_fwait = 0; m_dwait = 0; m_owed = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (m_halt) begin
            // frozen
        end else if (m_dwait && !dd) begin
            mwen = 1; mwbub = 1;
        end else if (m_fwait) begin
            idexen = 1; exm = 1; mwen = 1;
            if (br) begin
                pc = 1; iffl = 1; bub = 1; took = 1;
                if (id) begin go_f = 0; owed = 0; end
                else owed = 1;
            end else begin
                bub = hz;
                if (id && m_owed) begin iffl = 1; go_f = 0; owed = 0; end
                else if (id) begin pc = !hz; ifen = !hz; go_f = 0; end
                else iffl = !hz;
            end
        end else begin
            go_d = 0; go_f = 0;
            if (ht) go_halt = 1;
            else if (ds && !m_dwait) begin go_d = 1; mwen = 1; mwbub = 1; end
            else begin
                idexen = 1; exm = 1; mwen = 1;
                if (br) begin pc = 1; iffl = 1; bub = 1; took = 1; end
                else if (is) begin go_f = 1; bub = hz; iffl = !hz; end
                else begin pc = !hz; ifen = !hz; bub = hz; end
            end
        end
        e = {pc, ifen, iffl, idexen, bub, exm, mwen, mwbub, m_halt};
        if (!m_halt && !pc) m_stall++;
        if (took) m_flush++;
        m_halt = go_halt; m_fwait = go_f; m_dwait = go_d; m_owed = owed;
    endtask

    initial begin
        logic [8:0] e;
        int         est, efl;
        logic       r;
        logic [6:0] v;

        rst = 1'b1;
        {hazard_stall, branch_flush, imem_stall, imem_done, dmem_stall, dmem_done, halt_wb} = 7'd0;
        repeat (2) @(posedge clk);

        add(1, 0, RST_C, 0, 0);
        add(1, 0, RST_C, 0, 0);
        add(0, 0, RUN_C, 0, 0);
        add(0, I_HZ, HAZ_C, 0, 0);
        add(0, 0, RUN_C, 1, 0);
        add(0, I_DS, DMS_C, 1, 0);
        add(0, 0, DMS_C, 2, 0);
        add(0, 0, DMS_C, 3, 0);
        add(0, 0, DMS_C, 4, 0);
        add(0, I_DD, RUN_C, 5, 0);
        add(0, 0, RUN_C, 5, 0);
        add(0, I_DS, DMS_C, 5, 0);
        add(0, I_DD | I_BR | I_DS, BRF_C, 6, 0);
        add(0, 0, RUN_C, 6, 1);
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].r, tbl[i].in, tbl[i].ctrl, tbl[i].st, tbl[i].fl);

        // Fetch miss with a redirect arriving mid-miss.
        step("imiss_start", 0, I_IS, IMS_C, 6, 1);
        step("imiss_redirect", 0, I_BR, BRF_C, 7, 1);
        step("imiss_wait1", 0, 0, IMS_C, 7, 2);
        step("imiss_wait2", 0, 0, IMS_C, 8, 2);
        step("imiss_done_pend", 0, I_ID, IMS_C, 9, 2);
        step("imiss_resume", 0, 0, RUN_C, 10, 2);
        // Fetch return while decode is stalled: not captured.
        step("imiss_hz_start", 0, I_IS | I_HZ, HAZ_C, 10, 2);
        step("imiss_hz_done", 0, I_ID | I_HZ, HAZ_C, 11, 2);
        step("imiss_hz_resume", 0, 0, RUN_C, 12, 2);
        step("imiss_plain", 0, I_IS, IMS_C, 12, 2);
        step("imiss_plain_done", 0, I_ID, RUN_C, 13, 2);
        step("imiss_plain_run", 0, 0, RUN_C, 13, 2);

        // Halt outranks data miss and redirect; only reset leaves HALT.
        step("halt_prio", 0, I_HT | I_DS | I_BR, HLT0, 13, 2);
        step("halt_hold1", 0, I_BR | I_HZ, HLT1, 14, 2);
        step("halt_hold2", 0, I_DS | I_IS, HLT1, 14, 2);
        step("halt_hold3", 0, 0, HLT1, 14, 2);
        step("halt_rst", 1, 0, RST_C | HLT1, 14, 2);
        step("halt_exit", 0, 0, RUN_C, 0, 0);

        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), 0, I_HZ, HAZ_C, i, 0);
        step("sat_end", 0, 0, RUN_C, 20, 0);
        step("pre_rnd", 1, 0, RST_C, 20, 0);

        m_halt = 0; m_fwait = 0; m_dwait = 0; m_owed = 0; m_stall = 0; m_flush = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 79) == 0);
            v[6] = ($urandom_range(0, 3) == 0);
            v[5] = ($urandom_range(0, 6) == 0);
            v[4] = ($urandom_range(0, 6) == 0);
            v[3] = ($urandom_range(0, 2) == 0);
            v[2] = ($urandom_range(0, 9) == 0);
            v[1] = ($urandom_range(0, 2) == 0);
            v[0] = ($urandom_range(0, 199) == 0);
            model_step(r, v, e, est, efl);
            step($sformatf("rnd%0d", i), r, v, e, est, efl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
